// File: rtl/icmp_receiver.sv
// ICMP message receiver: reassembles header, typedata and data words and checks the RFC 1071 checksum.
// Define ICMP_TYPE_FILTER_EN to reject checksum-good messages whose type is not 0, 3, 8 or 11.
//
// state | meaning
// IDLE  | waiting for a word with sof
// RECV  | collecting words 1..NUM_DATA_WORDS+1, idle timeout armed
// CHECK | one cycle: verify checksum, publish fields or flag error
module icmp_receiver #(
    parameter int NUM_DATA_WORDS = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clock,
    input  logic                        actreset,
    input  logic [31:0]                 inword,
    input  logic                        inword_valid,
    input  logic                        sof,
    output logic                        in_ready,
    output logic [7:0]                  typeoficmp,
    output logic [7:0]                  code,
    output logic [15:0]                 rx_checksum,
    output logic [31:0]                 typedata,
    output logic [32*NUM_DATA_WORDS-1:0] payload,
    output logic                        msg_valid,
    output logic                        csum_err,
    output logic                        frame_err,
    output logic                        type_err,
    output logic                        busy
);
    localparam int NW = NUM_DATA_WORDS + 2;
    localparam int CW = $clog2(NW);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t              state, state_nxt;
    logic [NW-1:0][31:0] shadow;
    logic [15:0]         acc;
    logic [CW-1:0]       cnt;
    logic [TW-1:0]       idle_cnt;
    logic                accept, start, restart, timeout, last_word, csum_ok, type_ok;

    // ones'-complement add of both halves of a word, end-around carry folded twice
    function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [31:0] w);
        logic [17:0] s;
        logic [16:0] f;
        s = {2'b00, a} + {2'b00, w[31:16]} + {2'b00, w[15:0]};
        f = {1'b0, s[15:0]} + {15'b0, s[17:16]};
        return f[15:0] + {15'b0, f[16]};
    endfunction

    assign in_ready  = (state != CHECK);
    assign busy      = (state != IDLE);
    assign accept    = inword_valid & in_ready;
    assign start     = accept & sof;
    assign restart   = (state == RECV) & start;
    assign last_word = (cnt == CW'(NW - 1));
    assign timeout   = (state == RECV) & ~accept & (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign csum_ok   = (acc == 16'hFFFF);

`ifdef ICMP_TYPE_FILTER_EN
    assign type_ok = shadow[0][31:24] inside {8'd0, 8'd3, 8'd8, 8'd11};
`else
    assign type_ok  = 1'b1;
    assign type_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge actreset) begin
        if (actreset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RECV;
            RECV: begin
                if (accept) begin
                    if (!sof && last_word) state_nxt = CHECK;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge actreset) begin
        if (actreset) begin
            shadow      <= '0;
            acc         <= '0;
            cnt         <= '0;
            idle_cnt    <= '0;
            typeoficmp  <= '0;
            code        <= '0;
            rx_checksum <= '0;
            typedata    <= '0;
            payload     <= '0;
            msg_valid   <= 1'b0;
            csum_err    <= 1'b0;
            frame_err   <= 1'b0;
`ifdef ICMP_TYPE_FILTER_EN
            type_err    <= 1'b0;
`endif
        end else begin
            msg_valid <= 1'b0;
            csum_err  <= 1'b0;
            frame_err <= restart | timeout;
`ifdef ICMP_TYPE_FILTER_EN
            type_err  <= 1'b0;
`endif
            if (start) begin
                shadow[0] <= inword;
                acc       <= csum_add(16'h0000, inword);
                cnt       <= CW'(1);
                idle_cnt  <= '0;
            end else if (state == RECV && accept) begin
                shadow[cnt] <= inword;
                acc         <= csum_add(acc, inword);
                cnt         <= cnt + 1'b1;
                idle_cnt    <= '0;
            end else if (state == RECV) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (state == CHECK) begin
                if (!csum_ok) csum_err <= 1'b1;
`ifdef ICMP_TYPE_FILTER_EN
                else if (!type_ok) type_err <= 1'b1;
`endif
                else if (type_ok) begin
                    msg_valid   <= 1'b1;
                    typeoficmp  <= shadow[0][31:24];
                    code        <= shadow[0][23:16];
                    rx_checksum <= shadow[0][15:0];
                    typedata    <= shadow[1];
                    for (int i = 0; i < NUM_DATA_WORDS; i++)
                        payload[32*(NUM_DATA_WORDS-1-i) +: 32] <= shadow[2+i];
                end
            end
        end
    end
endmodule

// File: tb/tb_icmp_receiver.sv
// Self-checking bench for icmp_receiver: expected pulse events are queued at send time and matched by a monitor.
// Honours ICMP_TYPE_FILTER_EN when building expectations.
module tb_icmp_receiver;
    typedef logic [4:0][31:0] msg_t;
    typedef struct packed {
        logic [2:0]  kind;   // 1 valid, 2 csum, 3 frame, 4 type, 7 several at once
        logic [31:0] cyc;
        logic [7:0]  ty;
        logic [7:0]  cd;
        logic [15:0] cs;
        logic [31:0] td;
        logic [95:0] pl;
    } ev_t;

    logic        clock = 1'b0;
    logic        actreset;
    logic [31:0] inword;
    logic        inword_valid, sof;
    logic        in_ready, msg_valid, csum_err, frame_err, type_err, busy;
    logic [7:0]  typeoficmp, code;
    logic [15:0] rx_checksum;
    logic [31:0] typedata;
    logic [95:0] payload;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    ev_t  mon_o, mon_e;
    int   mon_n;
    logic [7:0]  held_ty = '0, held_cd = '0;
    logic [15:0] held_cs = '0;
    logic [31:0] held_td = '0;
    logic [95:0] held_pl = '0;
    logic [7:0]  tlist [6] = '{8'd0, 8'd3, 8'd8, 8'd11, 8'd5, 8'd13};

    icmp_receiver #(.NUM_DATA_WORDS(3), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .actreset(actreset), .inword(inword), .inword_valid(inword_valid),
        .sof(sof), .in_ready(in_ready), .typeoficmp(typeoficmp), .code(code),
        .rx_checksum(rx_checksum), .typedata(typedata), .payload(payload),
        .msg_valid(msg_valid), .csum_err(csum_err), .frame_err(frame_err),
        .type_err(type_err), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // monitor: every pulse is matched against the next queued expectation
    always @(negedge clock) begin
        if (!actreset) begin
            mon_n = int'(msg_valid) + int'(csum_err) + int'(frame_err) + int'(type_err);
            if (mon_n != 0) begin
                mon_o.kind = (mon_n > 1) ? 3'd7 : msg_valid ? 3'd1 : csum_err ? 3'd2 : frame_err ? 3'd3 : 3'd4;
                mon_o.cyc = cyc;
                mon_o.ty = typeoficmp; mon_o.cd = code; mon_o.cs = rx_checksum;
                mon_o.td = typedata;   mon_o.pl = payload;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_pulse got=%h required=none", mon_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_o !== mon_e) begin
                        errors++;
                        $display("FAIL sb_event got=%h required=%h", mon_o, mon_e);
                    end
                end
            end
        end
    end

    function automatic logic [15:0] ocsum(msg_t m);
        logic [31:0] s = 0;
        for (int i = 0; i < 5; i++) s = s + m[i][31:16] + m[i][15:0];
        while (s[31:16] != 0) s = s[15:0] + s[31:16];
        return s[15:0];
    endfunction

    function automatic msg_t fix_csum(msg_t m);
        m[0][15:0] = 16'h0000;
        m[0][15:0] = ~ocsum(m);
        return m;
    endfunction

    function automatic bit type_ok(logic [7:0] t);
        bit ok;
        ok = t inside {8'd0, 8'd3, 8'd8, 8'd11};
`ifndef ICMP_TYPE_FILTER_EN
        ok = 1'b1;
`endif
        return ok;
    endfunction

    task automatic push_ev(logic [2:0] kind, int c);
        ev_t x;
        x.kind = kind; x.cyc = c;
        x.ty = held_ty; x.cd = held_cd; x.cs = held_cs; x.td = held_td; x.pl = held_pl;
        exp_q.push_back(x);
    endtask

    task automatic expect_msg(msg_t m, int e);
        if (ocsum(m) == 16'hFFFF && type_ok(m[0][31:24])) begin
            held_ty = m[0][31:24]; held_cd = m[0][23:16]; held_cs = m[0][15:0];
            held_td = m[1]; held_pl = {m[2], m[3], m[4]};
            push_ev(3'd1, e + 1);
        end else if (ocsum(m) == 16'hFFFF) push_ev(3'd4, e + 1);
        else push_ev(3'd2, e + 1);
    endtask

    task automatic send_word(logic [31:0] w, logic s);
        int b = 0;
        inword = w; sof = s; inword_valid = 1'b1;
        while (!in_ready && b < 8) begin @(negedge clock); b++; end
        @(negedge clock);
    endtask

    task automatic send_msg(msg_t m, output int e);
        for (int i = 0; i < 5; i++) send_word(m[i], i == 0);
        inword_valid = 1'b0; sof = 1'b0;
        e = cyc;
    endtask

    task automatic wait_sb();
        int b = 0;
        while (exp_q.size() != 0 && b < 40) begin @(negedge clock); b++; end
        repeat (3) @(negedge clock);
    endtask

    task automatic reset_model();
        held_ty = '0; held_cd = '0; held_cs = '0; held_td = '0; held_pl = '0;
    endtask

    task automatic test_reset();
        actreset = 1'b1; inword = '0; inword_valid = 1'b0; sof = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, msg_valid, csum_err, frame_err, type_err} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl got=%b required=100000", {in_ready, busy, msg_valid, csum_err, frame_err, type_err});
        end
        checks++;
        if ({typeoficmp, code, rx_checksum, typedata, payload} !== '0) begin
            errors++; $display("FAIL reset_fields got=%h required=0", {typeoficmp, code, rx_checksum, typedata, payload});
        end
        repeat (2) @(negedge clock);
        actreset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_drop();
        send_word(32'h0800342A, 1'b0);
        inword_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got=%b required=0", busy); end
    endtask

    task automatic test_echo();
        msg_t m = {32'hDEADBEEF, 32'h0A000002, 32'h0A000001, 32'h12340001, 32'h0800342A};
        int e;
        send_msg(m, e);
        checks++;
        if ({busy, in_ready} !== 2'b10) begin errors++; $display("FAIL echo_check_state got=%b required=10", {busy, in_ready}); end
        expect_msg(m, e);
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL echo_missing pending=%0d required=0", exp_q.size()); exp_q.delete(); end
        checks++;
        if ({typeoficmp, code, rx_checksum, typedata, payload} !== {8'h08, 8'h00, 16'h342A, 32'h12340001, 96'h0A0000010A000002DEADBEEF}) begin
            errors++; $display("FAIL echo_fields got=%h", {typeoficmp, code, rx_checksum, typedata, payload});
        end
    endtask

    task automatic test_csum_err();
        msg_t m = {32'hDEADBEEF, 32'h0A000002, 32'h0A000001, 32'h12340001, 32'h0800342B};
        int e;
        send_msg(m, e);
        expect_msg(m, e);
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL csum_missing pending=%0d required=0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (rx_checksum !== 16'h342A) begin errors++; $display("FAIL csum_held got=%h required=342a", rx_checksum); end
    endtask

    task automatic test_timeout();
        msg_t m = fix_csum({32'h11112222, 32'h33334444, 32'h55556666, 32'h0000ABCD, 32'h00000000});
        int a, e;
        send_word(32'h08001111, 1'b1);
        send_word(32'h22223333, 1'b0);
        inword_valid = 1'b0;
        a = cyc;
        push_ev(3'd3, a + 16);
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_missing pending=%0d required=0", exp_q.size()); exp_q.delete(); end
        checks++;
        if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL timeout_state got=%b required=01", {busy, in_ready}); end
        send_msg(m, e);
        expect_msg(m, e);
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_recover pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_sof_restart();
        msg_t m = fix_csum({32'hCAFEF00D, 32'h01020304, 32'hA5A5A5A5, 32'h00070009, 32'h03010000});
        int e;
        send_word(32'h0800AAAA, 1'b1);
        send_word(32'h12345678, 1'b0);
        send_word(32'h9ABCDEF0, 1'b0);
        push_ev(3'd3, cyc + 1);
        send_msg(m, e);
        expect_msg(m, e);
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL sof_restart pending=%0d required=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_csum_zero_field();
        msg_t m = {32'h00000000, 32'h0BADF00D, 32'h01020304, 32'h00010002, 32'h08000000};
        int e;
        m[4][15:0] = ~ocsum(m);
        send_msg(m, e);
        expect_msg(m, e);
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL zero_field pending=%0d required=0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (rx_checksum !== 16'h0000 || typedata !== 32'h00010002) begin
            errors++; $display("FAIL zero_field_fields got=%h/%h required=0000/00010002", rx_checksum, typedata);
        end
    endtask

    task automatic test_type5();
        msg_t m = fix_csum({32'h10203040, 32'h50607080, 32'h0A0A0A0A, 32'h0A000001, 32'h05010000});
        int e;
        send_msg(m, e);
        expect_msg(m, e);
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL type5_missing pending=%0d required=0", exp_q.size()); exp_q.delete(); end
        checks++;
        if (typeoficmp !== held_ty) begin errors++; $display("FAIL type5_type got=%h required=%h", typeoficmp, held_ty); end
    endtask

    task automatic test_reset_recv();
        send_word(32'h0800342A, 1'b1);
        send_word(32'h12340001, 1'b0);
        inword_valid = 1'b0;
        #2 actreset = 1'b1;
        #1;
        reset_model();
        checks++;
        if ({in_ready, busy, frame_err} !== 3'b100) begin errors++; $display("FAIL rst_recv_ctrl got=%b required=100", {in_ready, busy, frame_err}); end
        checks++;
        if ({typeoficmp, typedata, payload} !== '0) begin errors++; $display("FAIL rst_recv_fields got=%h required=0", {typeoficmp, typedata, payload}); end
        @(negedge clock);
        actreset = 1'b0;
        repeat (20) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_recv_idle got=%b required=0", busy); end
    endtask

    task automatic test_reset_check();
        msg_t m = {32'hDEADBEEF, 32'h0A000002, 32'h0A000001, 32'h12340001, 32'h0800342A};
        int e;
        send_msg(m, e);
        #2 actreset = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, msg_valid, csum_err} !== 4'b1000) begin
            errors++; $display("FAIL rst_check_ctrl got=%b required=1000", {in_ready, busy, msg_valid, csum_err});
        end
        checks++;
        if (typeoficmp !== 8'h00) begin errors++; $display("FAIL rst_check_type got=%h required=00", typeoficmp); end
        @(negedge clock);
        actreset = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if ({busy, msg_valid, typeoficmp} !== 10'b0) begin errors++; $display("FAIL rst_check_after got=%h required=0", {busy, msg_valid, typeoficmp}); end
    endtask

    task automatic test_back_to_back();
        msg_t r;
        int e;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 5; i++) r[i] = $urandom;
            r[0][31:24] = tlist[$urandom_range(0, 5)];
            r = fix_csum(r);
            if (k % 3 == 1) r[2] = r[2] ^ 32'h00010000;
            send_msg(r, e);
            expect_msg(r, e);
        end
        wait_sb();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing pending=%0d required=0", exp_q.size()); exp_q.delete(); end
        checks++;
        if ({typeoficmp, typedata, payload} !== {held_ty, held_td, held_pl}) begin
            errors++; $display("FAIL b2b_fields got=%h required=%h", {typeoficmp, typedata, payload}, {held_ty, held_td, held_pl});
        end
    endtask

    initial begin
        test_reset();
        test_drop();
        test_echo();
        test_csum_err();
        test_timeout();
        test_sof_restart();
        test_csum_zero_field();
        test_type5();
        test_reset_recv();
        test_reset_check();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icmp_receiver.md
Name: icmp_receiver

Overview:
Receive-side counterpart of the ICMP message generator. Accepts an ICMP message as a stream of 32-bit words and reassembles the header, the type-specific word and the data words. Verifies the RFC 1071 ones'-complement checksum and presents the decoded fields with a one-cycle valid or error pulse. Sits between the link-side word deserializer and the ICMP control/response logic.

Parameters:
NUM_DATA_WORDS, 3, data words following the typedata word; total message = NUM_DATA_WORDS+2 words
TIMEOUT_CYCLES, 16, max consecutive idle cycles (inword_valid low) tolerated mid-message before abort

Ports:
clock  input  1  system clock, rising edge
actreset  input  1  reset, asynchronous, active-high
inword  input  32  received message word
inword_valid  input  1  inword valid this cycle
sof  input  1  qualifies inword as word 0 (header); sampled only with inword_valid
in_ready  output  1  receiver accepts a word this cycle
typeoficmp  output  8  type of last good message
code  output  8  code of last good message
rx_checksum  output  16  checksum field of last good message
typedata  output  32  word 1 of last good message
payload  output  32*NUM_DATA_WORDS  data words; word 2 in the MSBs
msg_valid  output  1  one-cycle pulse: good message, fields updated
csum_err  output  1  one-cycle pulse: checksum mismatch
frame_err  output  1  one-cycle pulse: timeout or truncated message
type_err  output  1  one-cycle pulse: type rejected (see Optional Feature)
busy  output  1  high while in RECV or CHECK

Behaviour:
- Reset (async): state IDLE; all outputs 0 except in_ready=1; accumulator, word counter, idle counter cleared. Reset mid-message discards the partial message with no pulse.
- Word accepted = inword_valid & in_ready, on a rising edge.
- States: IDLE, RECV, CHECK.
- IDLE: in_ready=1. Accepted word with sof=1 -> store word 0 into a shadow register, acc = hi16 + lo16 (folded), cnt=1 -> RECV. Accepted word with sof=0 is dropped silently.
- RECV: in_ready=1. On each accepted word:
  - If sof=0: store into shadow slot cnt; acc += hi16 + lo16 with end-around carry folded every cycle (18-bit add, fold twice to 16 bits); cnt++; idle counter cleared.
  - If sof=1: frame_err pulse, restart with this word as the new word 0.
  - After word NUM_DATA_WORDS+1 is accepted -> CHECK.
  - On cycles with no accepted word: idle counter increments. When it reaches TIMEOUT_CYCLES: frame_err pulse, -> IDLE.
- CHECK (one cycle): in_ready=0.
  - If acc == 16'hFFFF: copy shadow registers to the output fields and pulse msg_valid.
  - Otherwise pulse csum_err; output fields are unchanged.
  - Next state IDLE.
- Latency: the edge capturing the last word is edge E. The pulse is registered at E+1 and cleared at E+2. Output fields change only at E+1, and only for a good message.
- Pulses are mutually exclusive; at most one asserts per cycle.
- Ones'-complement arithmetic: 0xFFFF + 0x0001 folds to 0x0001. Both encodings of zero are handled by the fold. Only 0xFFFF passes.
- A message with checksum field 0x0000 is still verified; there is no "checksum disabled" exemption.

Optional Feature:
ICMP_TYPE_FILTER_EN
- Defined: in CHECK, a checksum-good message whose type is not in {0, 3, 8, 11} pulses type_err instead of msg_valid, and the output fields are not updated.
- Not defined: every type is accepted and type_err is tied 0.

Test Plan:
- Echo request: words 0x0800342A, 0x12340001, 0x0A000001, 0x0A000002, 0xDEADBEEF back-to-back with sof on the first. Required: msg_valid pulse at E+1; typeoficmp=0x08, code=0x00, rx_checksum=0x342A, typedata=0x12340001, payload=0x0A0000010A000002DEADBEEF.
- Same message with word 0 = 0x0800342B. Required: csum_err pulse, no msg_valid, fields still hold the previous message.
- Send 2 words, then hold inword_valid low for 16 cycles. Required: frame_err pulse on the 16th idle cycle, busy falls, in_ready=1. A subsequent good message decodes correctly.
- Send 3 words, then a word with sof=1 followed by the full good message. Required: frame_err pulse on the sof word, then msg_valid for the new message.
- Assert actreset mid-RECV, and separately during CHECK. Required: outputs clear asynchronously, no pulse, state IDLE, in_ready=1.
- With ICMP_TYPE_FILTER_EN: a valid-checksum type 0x05 message -> type_err pulse and no msg_valid. Without the macro: the same message -> msg_valid pulse with typeoficmp=0x05.
